// File: rtl/frix_led_pkg.sv
// Shared constants for the Frix board status LEDs: LED bit positions and
// parameter defaults used by frix_status_led and frix_led_stretch.
package frix_led_pkg;

  localparam int LED_HB     = 0;
  localparam int LED_ALIVE  = 1;
  localparam int LED_CPU    = 2;
  localparam int LED_SDCD   = 3;
  localparam int LED_SDRST  = 4;
  localparam int LED_SD_LO  = 5;
  localparam int LED_ACT_LO = 10;
  localparam int LED_PS2_LO = 14;

  localparam int STRETCH_CYCLES_DEF = 2500000;
  localparam int HB_W_DEF           = 26;

  // Four activity channels; eight asynchronous pins {ps2_clk, ps2_dat, sd_cmd, sd_dat[3:0], sd_cd}
  localparam int ACT_CH = 4;
  localparam int PIN_W  = 8;

endpackage

// File: rtl/frix_led_stretch.sv
// One activity LED channel: registers the strobe and, when FRIX_LED_STRETCH_EN
// is defined, stretches it so the LED stays lit STRETCH_CYCLES after the last hit.
module frix_led_stretch
  import frix_led_pkg::*;
#(
  parameter int STRETCH_CYCLES = STRETCH_CYCLES_DEF
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic act_in,
  output logic led
);

  if (STRETCH_CYCLES < 1) begin : g_bad_cfg
    $error("frix_led_stretch: STRETCH_CYCLES must be at least 1");
  end

  logic act_q;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) act_q <= 1'b0;
    else     act_q <= act_in;
  end

`ifdef FRIX_LED_STRETCH_EN
  localparam int CNT_W = $clog2(STRETCH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH_CYCLES);

  logic [CNT_W-1:0] cnt;

  // Reload wins over decrement so a retrigger restarts the whole window
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (act_q)       cnt <= CNT_LOAD;
    else if (cnt != '0)   cnt <= cnt - CNT_W'(1);
  end

  assign led = (cnt != '0);
`else
  assign led = act_q;
`endif

endmodule

// File: rtl/frix_status_led.sv
// Nexys4 DDR Frix status LEDs: heartbeat, alive, reset levels, synchronised
// SD/PS2 pin levels and activity channels (stretched when FRIX_LED_STRETCH_EN).
module frix_status_led
  import frix_led_pkg::*;
#(
  parameter int STRETCH_CYCLES = STRETCH_CYCLES_DEF,
  parameter int HB_W           = HB_W_DEF
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        ao486_reset,
  input  logic        sd_reset,
  input  logic [3:0]  act_in,
  input  logic        sd_cd,
  input  logic        sd_cmd,
  input  logic [3:0]  sd_dat,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [15:0] led
);

  logic [HB_W-1:0]   hb_cnt;
  logic              alive_q;
  logic              cpu_led_reg;
  logic              sdrst_led_reg;
  logic [PIN_W-1:0]  pin_raw;
  logic [PIN_W-1:0]  pin_sync1_reg;
  logic [PIN_W-1:0]  pin_sync2_reg;
  logic [PIN_W-1:0]  pin_led_reg;
  logic [ACT_CH-1:0] act_led;

  assign pin_raw = {ps2_clk, ps2_dat, sd_cmd, sd_dat, sd_cd};

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      hb_cnt        <= '0;
      alive_q       <= 1'b0;
      cpu_led_reg   <= 1'b0;
      sdrst_led_reg <= 1'b0;
      pin_sync1_reg <= '0;
      pin_sync2_reg <= '0;
      pin_led_reg   <= '0;
    end else begin
      hb_cnt        <= hb_cnt + HB_W'(1);
      alive_q       <= 1'b1;
      cpu_led_reg   <= ~ao486_reset;
      sdrst_led_reg <= ~sd_reset;
      pin_sync1_reg <= pin_raw;
      pin_sync2_reg <= pin_sync1_reg;
      pin_led_reg   <= ~pin_sync2_reg;
    end
  end

  for (genvar gi = 0; gi < ACT_CH; gi++) begin : g_act
    frix_led_stretch #(
      .STRETCH_CYCLES(STRETCH_CYCLES)
    ) u_stretch (
      .clk_sys(clk_sys),
      .rst    (rst),
      .act_in (act_in[gi]),
      .led    (act_led[gi])
    );
  end

  always_comb begin
    led                        = '0;
    led[LED_HB]                = hb_cnt[HB_W-1];
    led[LED_ALIVE]             = alive_q;
    led[LED_CPU]               = cpu_led_reg;
    led[LED_SDCD]              = pin_led_reg[0];
    led[LED_SDRST]             = sdrst_led_reg;
    led[LED_SD_LO +: 5]        = pin_led_reg[5:1];
    led[LED_ACT_LO +: ACT_CH]  = act_led;
    led[LED_PS2_LO +: 2]       = pin_led_reg[7:6];
  end

endmodule

// File: tb/tb_frix_status_led.sv
// Self-checking bench for frix_status_led with STRETCH_CYCLES=8, HB_W=4;
// expectations adapt to whether FRIX_LED_STRETCH_EN is defined.
module tb_frix_status_led;

`ifdef FRIX_LED_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif

  logic        clk_sys;
  logic        rst;
  logic        ao486_reset;
  logic        sd_reset;
  logic [3:0]  act_in;
  logic        sd_cd;
  logic        sd_cmd;
  logic [3:0]  sd_dat;
  logic        ps2_clk;
  logic        ps2_dat;
  logic [15:0] led;

  frix_status_led #(
    .STRETCH_CYCLES(8),
    .HB_W          (4)
  ) dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .ao486_reset(ao486_reset),
    .sd_reset   (sd_reset),
    .act_in     (act_in),
    .sd_cd      (sd_cd),
    .sd_cmd     (sd_cmd),
    .sd_dat     (sd_dat),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .led        (led)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [3:0]  act;
    logic [3:0]  sd_dat;
    logic        ps2_clk;
    logic        ao486;
    logic [15:0] mask;
    logic [15:0] exp_str;
    logic [15:0] exp_raw;
    string       name;
  } vec_t;

  typedef struct {
    int          due;
    logic [15:0] mask;
    logic [15:0] val;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   hb_k  = 0;
  bit   hb_en = 1'b0;

  task automatic check(input string name, input logic [15:0] mask, input logic [15:0] exp);
    total++;
    if ((led & mask) !== (exp & mask)) begin
      bad++;
      $display("FAIL %s cyc=%0d led=%h required=%h mask=%h", name, cyc, led & mask, exp & mask, mask);
    end else begin
      $display("ok   %s cyc=%0d led=%h", name, cyc, led & mask);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
    cyc++;
    if (hb_en) begin
      hb_k++;
      check("heartbeat", 16'h0001, {15'b0, ((hb_k % 16) >= 8)});
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].name, sb[i].mask, sb[i].val);
        sb.delete(i);
      end
    end
  endtask

  task automatic add(input logic [3:0] a, input logic [3:0] d, input logic p, input logic c,
                     input logic [15:0] m, input logic [15:0] es, input logic [15:0] er,
                     input string n);
    vec_t v;
    v.act = a; v.sd_dat = d; v.ps2_clk = p; v.ao486 = c;
    v.mask = m; v.exp_str = es; v.exp_raw = er; v.name = n;
    vecs.push_back(v);
  endtask

  // One-cycle strobe then idle: raw build lights for 1 edge, stretched for 8
  task automatic add_pulse(input logic [3:0] a, input logic [15:0] b, input string n);
    add(a, 4'h0, 1'b0, 1'b0, 16'h3C00, 16'h0000, b, n);
    for (int i = 0; i < 8; i++) add(4'h0, 4'h0, 1'b0, 1'b0, 16'h3C00, b, 16'h0000, n);
    add(4'h0, 4'h0, 1'b0, 1'b0, 16'h3C00, 16'h0000, 16'h0000, n);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    act_in      = v.act;
    sd_dat      = v.sd_dat;
    ps2_clk     = v.ps2_clk;
    ao486_reset = v.ao486;
    e.due  = cyc + 1;
    e.mask = v.mask;
    e.val  = STRETCH ? v.exp_str : v.exp_raw;
    e.name = v.name;
    sb.push_back(e);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;

    add_pulse(4'b1000, 16'h2000, "act13_pulse");
    add(4'b0001, 4'h0, 1'b0, 1'b0, 16'h3C00, 16'h0000, 16'h0400, "retrig");
    for (int i = 0; i < 4; i++) add(4'h0, 4'h0, 1'b0, 1'b0, 16'h3C00, 16'h0400, 16'h0000, "retrig");
    add(4'b0001, 4'h0, 1'b0, 1'b0, 16'h3C00, 16'h0400, 16'h0400, "retrig");
    for (int i = 0; i < 8; i++) add(4'h0, 4'h0, 1'b0, 1'b0, 16'h3C00, 16'h0400, 16'h0000, "retrig");
    add(4'h0, 4'h0, 1'b0, 1'b0, 16'h3C00, 16'h0000, 16'h0000, "retrig");
    add_pulse(4'b0110, 16'h1800, "act_dual");
    add_pulse(4'b0100, 16'h1000, "act12_pulse");
    add(4'h0, 4'hA, 1'b1, 1'b1, 16'h81E4, 16'h81E0, 16'h81E0, "pins_set");
    add(4'h0, 4'hA, 1'b1, 1'b1, 16'h81E4, 16'h81E0, 16'h81E0, "pins_set");
    add(4'h0, 4'hA, 1'b1, 1'b1, 16'h81E4, 16'h00A0, 16'h00A0, "pins_set");
    add(4'h0, 4'hA, 1'b1, 1'b1, 16'h81E4, 16'h00A0, 16'h00A0, "pins_set");
    add(4'h0, 4'h0, 1'b0, 1'b0, 16'h81E4, 16'h00A4, 16'h00A4, "pins_clr");
    add(4'h0, 4'h0, 1'b0, 1'b0, 16'h81E4, 16'h00A4, 16'h00A4, "pins_clr");
    add(4'h0, 4'h0, 1'b0, 1'b0, 16'h81E4, 16'h81E4, 16'h81E4, "pins_clr");

    rst = 1'b1; ao486_reset = 1'b0; sd_reset = 1'b0; act_in = 4'h0;
    sd_cd = 1'b0; sd_cmd = 1'b0; sd_dat = 4'h0; ps2_clk = 1'b0; ps2_dat = 1'b0;
    #1;
    check("reset_state", 16'hFFFF, 16'h0000);
    step();
    step();
    check("reset_held", 16'hFFFF, 16'h0000);

    rst = 1'b0; hb_k = 0; hb_en = 1'b1;
    step();
    check("post_rst_all", 16'hFFFF, 16'hC3FE);
    repeat (32) step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of a stretch window
    act_in = 4'b1000;
    step();
    act_in = 4'h0;
    step();
    check("pre_rst_lit", 16'h3C00, STRETCH ? 16'h2000 : 16'h0000);
    #2 rst = 1'b1;
    hb_en = 1'b0;
    #1;
    check("rst_async", 16'hFFFF, 16'h0000);
    @(posedge clk_sys);
    #1;
    cyc++;
    check("rst_still", 16'hFFFF, 16'h0000);
    rst = 1'b0; hb_k = 0; hb_en = 1'b1;
    step();
    check("alive_after_rst", 16'h0003, 16'h0002);
    for (int i = 0; i < 10; i++) begin
      e.due = cyc + 1; e.mask = 16'h3C00; e.val = 16'h0000; e.name = "no_residual";
      sb.push_back(e);
      step();
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    while (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s never checked due=%0d", sb[0].name, sb[0].due);
      sb.delete(0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
